// File: rtl/axi_pkg.sv
// Shared AXI read-responder definitions: burst/resp encodings, FSM states,
// the latched AR control payload and the WRAP legality helper.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_LAST = 2'd2
  } state_e;

  // Burst shape captured at the AR handshake.
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } ar_ctrl_t;

  // WRAP needs a power-of-two beat count (2/4/8/16) and at most 8-byte beats.
  function automatic logic wrap_illegal(input logic [1:0] burst,
                                        input logic [7:0] len,
                                        input logic [2:0] size);
    return (burst == BURST_WRAP) &&
           (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || (size > 3'd3));
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address generator (combinational).
// Ports: addr/len/size/burst of the current beat -> next_addr_c.
// FIXED holds, INCR and reserved (11) step by 1<<size, WRAP steps within an
// aligned (len+1)<<size window.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr_c
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    step        = ADDR_WIDTH'(1) << size;
    incr_addr   = addr + step;
    // Window is a power of two for legal WRAP lengths, so a mask aligns it.
    wrap_mask   = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    next_addr_c = incr_addr;
    case (burst)
      BURST_FIXED: next_addr_c = addr;
      BURST_INCR:  next_addr_c = incr_addr;
      BURST_WRAP:  next_addr_c = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr_c = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read-only slave backed by a preloadable word memory.
// Ports: clk, reset (async active-low); AR channel s_axi_ar*; R channel
// s_axi_r*; preload ld_en/ld_addr/ld_data; busy while a burst is outstanding.
// Macro AXI_RD_ERR_EN: out-of-range words return DECERR with zero data and
// illegal WRAP bursts return SLVERR; otherwise the word index wraps modulo
// MEM_WORDS and the response is always OKAY.
module axi_rd_responder
  import axi_pkg::*;
#(
  parameter  int unsigned ID_WIDTH   = 13,
  parameter  int unsigned ADDR_WIDTH = 64,
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned MEM_WORDS  = 1024,
  localparam int unsigned IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic                  ld_en,
  input  logic [IDX_W-1:0]      ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  busy
);

  localparam int unsigned WORD_W = ADDR_WIDTH - 3;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  state_e                state_q,   state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q,  rvalid_d;
  logic                  rlast_q,   rlast_d;
  logic                  busy_q,    busy_d;
  logic [1:0]            rresp_q,   rresp_d;
  logic [ID_WIDTH-1:0]   rid_q,     rid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  ar_ctrl_t              ctrl_q,    ctrl_d;
  logic [7:0]            beat_q,    beat_d;

  logic                  ar_hs;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [WORD_W-1:0]     fetch_word;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic [1:0]            fetch_resp;

  axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_burst_addr (
    .addr        (addr_q),
    .len         (ctrl_q.len),
    .size        (ctrl_q.size),
    .burst       (ctrl_q.burst),
    .next_addr_c (next_addr)
  );

  // Preload port; memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  assign ar_hs = (state_q == ST_IDLE) && arready_q && s_axi_arvalid;

  // Address of the beat about to be registered: the AR address on the
  // handshake, otherwise the successor of the beat now on the bus.
  assign fetch_addr = (state_q == ST_IDLE) ? s_axi_araddr : next_addr;
  assign fetch_word = WORD_W'(fetch_addr >> 3);

`ifdef AXI_RD_ERR_EN
  logic slverr_q, slverr_d;
  logic fetch_slverr;
  logic fetch_oor;

  assign fetch_slverr = (state_q == ST_IDLE) ?
                        wrap_illegal(s_axi_arburst, s_axi_arlen, s_axi_arsize) : slverr_q;
  assign fetch_oor    = fetch_word >= WORD_W'(MEM_WORDS);
  assign fetch_data   = fetch_oor ? '0 : mem[IDX_W'(fetch_word)];
  assign fetch_resp   = fetch_slverr ? RESP_SLVERR :
                        fetch_oor    ? RESP_DECERR : RESP_OKAY;
  assign slverr_d     = ar_hs ? fetch_slverr : slverr_q;

  // SLVERR is a property of the whole burst, decided at the AR handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) slverr_q <= 1'b0;
    else        slverr_q <= slverr_d;
  end
`else
  assign fetch_data = mem[IDX_W'(fetch_word % WORD_W'(MEM_WORDS))];
  assign fetch_resp = RESP_OKAY;
`endif

  // Next-state and registered R-channel payload.
  always_comb begin
    state_d = state_q;
    rresp_d = rresp_q;
    rid_d   = rid_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    ctrl_d  = ctrl_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          state_d = (s_axi_arlen == 8'd0) ? ST_LAST : ST_BEAT;
          rid_d   = s_axi_arid;
          addr_d  = s_axi_araddr;
          ctrl_d  = '{len: s_axi_arlen, size: s_axi_arsize, burst: s_axi_arburst};
          beat_d  = 8'd0;
          rdata_d = fetch_data;
          rresp_d = fetch_resp;
        end
      end
      ST_BEAT: begin
        if (s_axi_rready) begin
          state_d = (8'(beat_q + 8'd1) == ctrl_q.len) ? ST_LAST : ST_BEAT;
          addr_d  = next_addr;
          beat_d  = 8'(beat_q + 8'd1);
          rdata_d = fetch_data;
          rresp_d = fetch_resp;
        end
      end
      ST_LAST: begin
        if (s_axi_rready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rvalid_d  = (state_d != ST_IDLE);
    rlast_d   = (state_d == ST_LAST);
    busy_d    = (state_d != ST_IDLE);
    arready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      rdata_q   <= '0;
      addr_q    <= '0;
      ctrl_q    <= '0;
      beat_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      busy_q    <= busy_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      ctrl_q    <= ctrl_d;
      beat_q    <= beat_d;
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign busy          = busy_q;

endmodule

// File: doc/axi_rd_responder.md
AXI_RD_RESPONDER -- requirements
Module: axi_rd_responder

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 13, AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, R data width (8 bytes/word).
REQ-004 SHALL have parameter MEM_WORDS, default 1024, backing-store depth in DATA_WIDTH words.
REQ-005 SHALL have ports clk in 1 (the one clock, rising edge) and reset in 1 (asynchronous, active-low).
REQ-006 SHALL have ports s_axi_arid in ID_WIDTH, s_axi_araddr in ADDR_WIDTH, s_axi_arlen in 8, s_axi_arsize in 3, s_axi_arburst in 2, s_axi_arvalid in 1 and s_axi_arready out 1.
REQ-007 SHALL have ports s_axi_rid out ID_WIDTH, s_axi_rdata out DATA_WIDTH, s_axi_rresp out 2, s_axi_rlast out 1, s_axi_rvalid out 1 and s_axi_rready in 1.
REQ-008 SHALL have preload ports ld_en in 1, ld_addr in log2(MEM_WORDS) (word index) and ld_data in DATA_WIDTH.
REQ-009 SHALL have status output busy out 1, high while a burst is outstanding.

Function
REQ-010 SHALL run a 3-state FSM: IDLE, BEAT, LAST.
REQ-011 SHALL drive arready=1 only in IDLE; AR handshake = arvalid&&arready; latch id/addr/len/size/burst; go to BEAT, or to LAST when arlen=0.
REQ-012 SHALL assert rvalid exactly 1 cycle after the AR handshake (first-beat latency 1).
REQ-013 SHALL hold rdata/rresp/rid/rlast stable while rvalid&&!rready.
REQ-014 SHALL advance 1 beat per rvalid&&rready cycle with no bubbles between beats.
REQ-015 SHALL make beat count arlen+1; rlast=1 only on the final beat; LAST handshake goes to IDLE, rvalid=0 next cycle.
REQ-016 SHALL present in rdata the full word at memory index addr[...:3] for the current beat address; narrow sizes are not lane-masked.
REQ-017 SHALL compute addresses as: FIXED(00) constant; INCR(01) +(1<<arsize); WRAP(10) +(1<<arsize) within boundary size (arlen+1)<<arsize, aligned down, wrapping to base.
REQ-018 SHALL treat burst=11 as INCR.
REQ-019 SHALL echo rid = latched arid on every beat.
REQ-020 SHALL use rresp=00 (OKAY) unless REQ-027 applies.
REQ-021 SHALL write ld_data into the word at ld_addr on the ld_en clock edge; a write during a burst to the word being presented appears no earlier than the next beat.
REQ-022 SHALL drive busy=1 from the cycle after the AR handshake through the LAST handshake cycle.

Reset
REQ-023 SHALL on reset low, immediately and asynchronously, clear: state=IDLE, arready=0, rvalid=0, rlast=0, rresp=00, rid=0, rdata=0, busy=0.
REQ-024 SHALL drive arready=1 on the first clk edge after reset is released.
REQ-025 SHALL abandon any in-flight burst on reset mid-burst, with no further beats.
REQ-026 SHALL not clear memory contents on reset.

Configuration
REQ-027 SHALL implement macro AXI_RD_ERR_EN: when defined, word index >= MEM_WORDS gives rresp=11 (DECERR) with rdata=0, and WRAP with arlen not in {1,3,7,15} or arsize>3 gives rresp=10 (SLVERR) for the whole burst (beat count unchanged); when undefined, the index is taken modulo MEM_WORDS and rresp is always 00.

Structure
REQ-028 SHALL place burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY/SLVERR/DECERR) and the FSM state enum in shared package axi_pkg.
REQ-029 SHALL compute next-beat addresses in one sub-module, axi_burst_addr (combinational: addr, len, size, burst -> next addr).

Verification
REQ-030 SHALL test: preload word0=64'h00000013_00000093, AR addr 0, len 7, size 3, WRAP, id 5 -> 8 beats at words 0..7, rid=5, rlast on beat 8, resp 00.
REQ-031 SHALL test: WRAP addr 0x28, len 7, size 3 -> word order 5,6,7,0,1,2,3,4.
REQ-032 SHALL test: INCR len 3 with rready low for 3 cycles on beat 2 -> beat 2 data stable; total 4 beats; no duplicates.
REQ-033 SHALL test: reset low mid-beat 3 of 8 -> rvalid=0 immediately; arready=1 on the first edge after release; a new burst returns correct data.
REQ-034 SHALL test with AXI_RD_ERR_EN: INCR addr MEM_WORDS*8, len 1 -> 2 beats with resp 11 and rdata 0; WRAP len 2 -> 3 beats with resp 10.
REQ-035 SHALL test: back-to-back ARs -> second arready only after the first rlast handshake; idle gap of 1 cycle.
